// File: rtl/piso_shift_tx.sv
// piso_shift_tx: parallel-in, serial-out transmit shift register.
// Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit
// per SHIFT_EN edge on SER_OUT, with SER_VALID and LAST framing. A new word
// can be accepted on the edge that consumes the final bit, so back-to-back
// words stream with no idle gap.
module piso_shift_tx #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          LSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic             CLK,
  input  logic             N_RESET,
  input  logic             SHIFT_EN,
  input  logic             LOAD_VALID,
  output logic             LOAD_READY,
  input  logic [WIDTH-1:0] DATA_IN,
  output logic             SER_OUT,
  output logic             SER_VALID,
  output logic             LAST
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;

  logic             final_bit;
  logic             accept;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] sreg_shifted;

  // The bit currently on SER_OUT is always held at the output end of sreg;
  // these decode the first bit of a new word and the bit that follows.
  always_comb begin
    first_bit    = 1'b0;
    next_bit     = 1'b0;
    sreg_shifted = '0;
    if (LSB_FIRST) begin
      first_bit    = DATA_IN[0];
      next_bit     = sreg[1];
      sreg_shifted = sreg >> 1;
    end else begin
      first_bit    = DATA_IN[WIDTH-1];
      next_bit     = sreg[WIDTH-2];
      sreg_shifted = sreg << 1;
    end
  end

  // Handshake: ready in IDLE, or on the edge that consumes the final bit.
  // Held low while reset is asserted.
  always_comb begin
    final_bit  = (state == SHIFT) && (cnt == CNT_LAST);
    LOAD_READY = !N_RESET &&
                 ((state == IDLE) || (final_bit && SHIFT_EN));
    accept     = LOAD_VALID && LOAD_READY;
    LAST       = final_bit;
  end

  // Two-state FSM with shift register, bit counter and registered outputs.
  always_ff @(posedge CLK or posedge N_RESET) begin
    if (N_RESET) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      SER_OUT   <= IDLE_LEVEL;
      SER_VALID <= 1'b0;
    end else begin
      if (accept) begin
        sreg      <= DATA_IN;
        cnt       <= '0;
        state     <= SHIFT;
        SER_OUT   <= first_bit;
        SER_VALID <= 1'b1;
      end else if ((state == SHIFT) && SHIFT_EN) begin
        if (final_bit) begin
          state     <= IDLE;
          SER_OUT   <= IDLE_LEVEL;
          SER_VALID <= 1'b0;
        end else begin
          sreg    <= sreg_shifted;
          SER_OUT <= next_bit;
          cnt     <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Directed testbench for piso_shift_tx: one LSB-first and one MSB-first
// instance sharing stimulus, each feeding a loopback SIPO receiver.
module tb_piso_shift_tx;

  logic       clk;
  logic       n_reset;
  logic       shift_en;
  logic       load_valid;
  logic [7:0] data_in;

  logic load_ready, ser_out, ser_valid, last;
  logic load_ready_m, ser_out_m, ser_valid_m, last_m;

  logic [7:0] sipo;
  logic [7:0] sipo_m;

  int checks = 0;
  int errors = 0;

  piso_shift_tx #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut (
    .CLK       (clk),
    .N_RESET   (n_reset),
    .SHIFT_EN  (shift_en),
    .LOAD_VALID(load_valid),
    .LOAD_READY(load_ready),
    .DATA_IN   (data_in),
    .SER_OUT   (ser_out),
    .SER_VALID (ser_valid),
    .LAST      (last)
  );

  piso_shift_tx #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_m (
    .CLK       (clk),
    .N_RESET   (n_reset),
    .SHIFT_EN  (shift_en),
    .LOAD_VALID(load_valid),
    .LOAD_READY(load_ready_m),
    .DATA_IN   (data_in),
    .SER_OUT   (ser_out_m),
    .SER_VALID (ser_valid_m),
    .LAST      (last_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Loopback receivers: shift on SER_VALID & SHIFT_EN at the consuming edge.
  always @(posedge clk) begin
    if (ser_valid && shift_en) sipo <= {ser_out, sipo[7:1]};
    if (ser_valid_m && shift_en) sipo_m <= {sipo_m[6:0], ser_out_m};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a word with SHIFT_EN=se; returns one cycle after the accepting edge.
  task automatic load_word(input logic [7:0] w, input logic se);
    load_valid = 1'b1;
    data_in    = w;
    shift_en   = se;
    step();
    load_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_reset = 1'b1; shift_en = 1'b0; load_valid = 1'b0; data_in = '0;
    #1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ser_out, ser_valid, last, load_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_held got out/valid/last/ready=%b exp 0000",
               {ser_out, ser_valid, last, load_ready});
    end
    n_reset = 1'b0;
    #1;
    checks++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b exp 1", load_ready);
    end
    // Mid-word reset, asserted between clock edges.
    step();
    load_word(8'hFF, 1'b1);
    step(); step(); step();
    #3;
    n_reset = 1'b1;
    #1;
    checks++;
    if ({ser_out, ser_valid, last, load_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_midword got out/valid/last/ready=%b exp 0000",
               {ser_out, ser_valid, last, load_ready});
    end
    step();
    n_reset  = 1'b0;
    shift_en = 1'b0;
    #1;
    checks++;
    if ({load_ready, ser_valid} !== 2'b10) begin
      errors++;
      $display("FAIL reset_midword_release got ready/valid=%b exp 10",
               {load_ready, ser_valid});
    end
    step();
  endtask

  task automatic test_single_word();
    logic exp_bits [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    load_word(8'b10101101, 1'b1);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({ser_out, ser_valid, last} !== {exp_bits[i], 1'b1, (i == 7)}) begin
        errors++;
        $display("FAIL single_bit%0d got out/valid/last=%b exp %b", i,
                 {ser_out, ser_valid, last}, {exp_bits[i], 1'b1, (i == 7)});
      end
      step();
    end
    checks++;
    if ({ser_out, ser_valid, last} !== 3'b000) begin
      errors++;
      $display("FAIL single_idle got out/valid/last=%b exp 000",
               {ser_out, ser_valid, last});
    end
    checks++;
    if (sipo !== 8'b10101101) begin
      errors++;
      $display("FAIL single_sipo got %h exp ad", sipo);
    end
  endtask

  task automatic test_back_to_back();
    // 8'hAD then 8'h3C, LSB first.
    logic exp_bits [16] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                            1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    load_valid = 1'b1; data_in = 8'hAD; shift_en = 1'b1;
    step();
    data_in = 8'h3C;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) load_valid = 1'b0;
      #0;
      checks++;
      if ({ser_out, ser_valid, last} !==
          {exp_bits[i], 1'b1, (i == 7 || i == 15)}) begin
        errors++;
        $display("FAIL b2b_bit%0d got out/valid/last=%b exp %b", i,
                 {ser_out, ser_valid, last},
                 {exp_bits[i], 1'b1, (i == 7 || i == 15)});
      end
      if (i < 8) begin
        checks++;
        if (load_ready !== (i == 7)) begin
          errors++;
          $display("FAIL b2b_ready%0d got %b exp %b", i, load_ready, (i == 7));
        end
      end
      step();
    end
    checks++;
    if ({ser_valid, sipo} !== {1'b0, 8'h3C}) begin
      errors++;
      $display("FAIL b2b_end got valid/sipo=%b/%h exp 0/3c", ser_valid, sipo);
    end
  endtask

  task automatic test_slow_enable();
    logic exp_bits [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    load_word(8'hAD, 1'b0);
    for (int k = 0; k < 24; k++) begin
      shift_en = (k % 3 == 2);
      #0;
      checks++;
      if ({ser_out, ser_valid} !== {exp_bits[k / 3], 1'b1}) begin
        errors++;
        $display("FAIL slow_cycle%0d got out/valid=%b exp %b", k,
                 {ser_out, ser_valid}, {exp_bits[k / 3], 1'b1});
      end
      step();
    end
    shift_en = 1'b1;
    checks++;
    if ({ser_valid, sipo} !== {1'b0, 8'hAD}) begin
      errors++;
      $display("FAIL slow_end got valid/sipo=%b/%h exp 0/ad", ser_valid, sipo);
    end
  endtask

  task automatic test_midword_load();
    logic exp_bits [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    load_word(8'hAD, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (i >= 3) load_valid = 1'b1;
      data_in = (i % 2 == 1 && i != 7) ? 8'h00 : 8'hFF;
      #0;
      checks++;
      if ({ser_out, ser_valid, load_ready} !== {exp_bits[i], 1'b1, (i == 7)}) begin
        errors++;
        $display("FAIL midload_bit%0d got out/valid/ready=%b exp %b", i,
                 {ser_out, ser_valid, load_ready}, {exp_bits[i], 1'b1, (i == 7)});
      end
      step();
    end
    load_valid = 1'b0;
    data_in    = 8'h00;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({ser_out, ser_valid, last} !== {1'b1, 1'b1, (i == 7)}) begin
        errors++;
        $display("FAIL midload_ff%0d got out/valid/last=%b exp %b", i,
                 {ser_out, ser_valid, last}, {1'b1, 1'b1, (i == 7)});
      end
      step();
    end
    checks++;
    if ({ser_valid, sipo} !== {1'b0, 8'hFF}) begin
      errors++;
      $display("FAIL midload_end got valid/sipo=%b/%h exp 0/ff", ser_valid, sipo);
    end
  endtask

  task automatic test_msb_first();
    logic exp_bits [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    load_word(8'b10101101, 1'b1);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({ser_out_m, ser_valid_m, last_m} !== {exp_bits[i], 1'b1, (i == 7)}) begin
        errors++;
        $display("FAIL msb_bit%0d got out/valid/last=%b exp %b", i,
                 {ser_out_m, ser_valid_m, last_m}, {exp_bits[i], 1'b1, (i == 7)});
      end
      step();
    end
    checks++;
    if ({ser_out_m, ser_valid_m, sipo_m} !== {1'b0, 1'b0, 8'hAD}) begin
      errors++;
      $display("FAIL msb_end got out/valid/sipo=%b/%b/%h exp 0/0/ad",
               ser_out_m, ser_valid_m, sipo_m);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_slow_enable();
    test_midword_load();
    test_msb_first();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
